decode_stage: RTL and testbench

- RV32I instruction decode stage that produces the control fields consumed by the ALU (alu_funct3_e / alu_funct7_e from package types), plus register addresses, the immediate and writeback control.
- Sits between fetch and execute, with a valid/ready handshake on both sides.
- A 2-entry output buffer (output register plus skid register) keeps instr_ready_o registered, so there is no combinational ready path from execute back to fetch.

---
 rtl/decode_stage.sv | 180 ++++++++++++++++++
 tb/tb_decode_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of instr_i registered into a
// 2-entry output buffer (output + skid) so instr_ready_o is a flop output.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] imm_o,
  output logic            use_imm_o,
  output logic            rd_we_o,
  output logic            illegal_o
);

  typedef enum logic [1:0] {EMPTY, HOLD1, HOLD2} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            rd_we;
    logic            illegal;
  } bundle_t;

  state_e  state_q, state_d;
  logic    ready_q, ready_d;
  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  bundle_t dec;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic is_r, is_i, is_s, is_b, is_u, is_j, is_opimm;
  logic accept, take;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];

  always_comb begin
    is_r = 1'b0; is_i = 1'b0; is_s = 1'b0;
    is_b = 1'b0; is_u = 1'b0; is_j = 1'b0;
    case (opcode)
      7'b0110011:                         is_r = 1'b1;
      7'b0010011, 7'b0000011, 7'b1100111: is_i = 1'b1;
      7'b0100011:                         is_s = 1'b1;
      7'b1100011:                         is_b = 1'b1;
      7'b0110111, 7'b0010111:             is_u = 1'b1;
      7'b1101111:                         is_j = 1'b1;
      default: ;
    endcase
  end

  assign is_opimm = (opcode == 7'b0010011);

  always_comb begin
    dec     = '0;
    dec.pc  = pc_i;
    // Every listed opcode ends in 2'b11, so an unknown opcode also covers instr[1:0] != 11.
    dec.illegal = !(is_r | is_i | is_s | is_b | is_u | is_j);
    if (is_r) begin
      if (f7 != 7'b0000000 && f7 != 7'b0100000) dec.illegal = 1'b1;
      if (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101) dec.illegal = 1'b1;
    end
    if (is_opimm) begin
      if (f3 == 3'b001 && f7 != 7'b0000000) dec.illegal = 1'b1;
      if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) dec.illegal = 1'b1;
    end

    if (is_r) begin
      dec.f3 = f3;
      dec.f7 = f7;
    end else if (is_opimm) begin
      dec.f3 = f3;
      dec.f7 = (f3 == 3'b101) ? f7 : 7'b0000000;
    end else if (is_b) begin
      dec.f3 = f3;
      dec.f7 = 7'b0100000;
    end

    if (is_i)
      dec.imm = {{20{instr_i[31]}}, instr_i[31:20]};
    else if (is_s)
      dec.imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    else if (is_b)
      dec.imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    else if (is_u)
      dec.imm = {instr_i[31:12], 12'b0};
    else if (is_j)
      dec.imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    dec.rs1     = (is_r | is_i | is_s | is_b) ? instr_i[19:15] : 5'd0;
    dec.rs2     = (is_r | is_s | is_b) ? instr_i[24:20] : 5'd0;
    dec.rd      = (is_r | is_i | is_u | is_j) ? instr_i[11:7] : 5'd0;
    dec.use_imm = is_i | is_s | is_u | is_j;
    dec.rd_we   = (dec.rd != 5'd0) & (is_r | is_i | is_u | is_j) & !dec.illegal;
  end

  assign accept = instr_valid_i & ready_q;
  assign take   = (state_q != EMPTY) & dec_ready_i;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    // Flush wins: a same-cycle take has already completed, an offered instruction is dropped.
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d = HOLD1;
          out_d   = dec;
        end
        HOLD1: begin
          if (accept && take) begin
            out_d = dec;
          end else if (accept) begin
            state_d = HOLD2;
            skid_d  = dec;
          end else if (take) begin
            state_d = EMPTY;
          end
        end
        HOLD2: if (take) begin
          state_d = HOLD1;
          out_d   = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
    ready_d = (state_d != HOLD2);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign instr_ready_o = ready_q;
  assign dec_valid_o   = (state_q != EMPTY);
  assign pc_o          = out_q.pc;
  assign funct3_o      = out_q.f3;
  assign funct7_o      = out_q.f7;
  assign rs1_addr_o    = out_q.rs1;
  assign rs2_addr_o    = out_q.rs2;
  assign rd_addr_o     = out_q.rd;
  assign imm_o         = out_q.imm;
  assign use_imm_o     = out_q.use_imm;
  assign rd_we_o       = out_q.rd_we;
  assign illegal_o     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, buffering/backpressure,
// illegal encodings, flush and asynchronous reset.
module tb_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic        dec_valid_o;
  logic        dec_ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [31:0] imm_o;
  logic        use_imm_o, rd_we_o, illegal_o;

  int nvec = 0;
  int nerr = 0;

  decode_stage #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .pc_o(pc_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
    .imm_o(imm_o), .use_imm_o(use_imm_o), .rd_we_o(rd_we_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  localparam logic [31:0] ADDI1 = 32'h0010_0093;
  localparam logic [31:0] ADDI2 = 32'h0020_0113;
  localparam logic [31:0] ADDI3 = 32'h0030_0193;

  initial begin
    #1 rst_i = 1'b1;
    #1;
    chk("rst_valid", {31'b0, dec_valid_o}, 32'd0);
    chk("rst_ready", {31'b0, instr_ready_o}, 32'd1);
    chk("rst_imm", imm_o, 32'd0);
    chk("rst_rd", {27'b0, rd_addr_o}, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    cyc(); cyc();
    rst_i = 1'b0;
    cyc();

    // ADD x3,x1,x2
    dec_ready_i = 1'b1; instr_valid_i = 1'b1; instr_i = 32'h0020_81B3; pc_i = 32'h100;
    cyc();
    chk("add_valid", {31'b0, dec_valid_o}, 32'd1);
    chk("add_pc", pc_o, 32'h100);
    chk("add_f3", {29'b0, funct3_o}, 32'd0);
    chk("add_f7", {25'b0, funct7_o}, 32'd0);
    chk("add_rs1", {27'b0, rs1_addr_o}, 32'd1);
    chk("add_rs2", {27'b0, rs2_addr_o}, 32'd2);
    chk("add_rd", {27'b0, rd_addr_o}, 32'd3);
    chk("add_useimm", {31'b0, use_imm_o}, 32'd0);
    chk("add_we", {31'b0, rd_we_o}, 32'd1);
    chk("add_ill", {31'b0, illegal_o}, 32'd0);
    chk("add_imm", imm_o, 32'd0);

    // SUB x5,x6,x7
    instr_i = 32'h4073_02B3; pc_i = 32'h104;
    cyc();
    chk("sub_f7", {25'b0, funct7_o}, 32'h20);
    chk("sub_rd", {27'b0, rd_addr_o}, 32'd5);
    chk("sub_rs1", {27'b0, rs1_addr_o}, 32'd6);
    chk("sub_rs2", {27'b0, rs2_addr_o}, 32'd7);
    chk("sub_pc", pc_o, 32'h104);

    // ADDI x1,x0,-1
    instr_i = 32'hFFF0_0093; pc_i = 32'h108;
    cyc();
    chk("addi_imm", imm_o, 32'hFFFF_FFFF);
    chk("addi_f7", {25'b0, funct7_o}, 32'd0);
    chk("addi_useimm", {31'b0, use_imm_o}, 32'd1);
    chk("addi_rs2", {27'b0, rs2_addr_o}, 32'd0);
    chk("addi_we", {31'b0, rd_we_o}, 32'd1);

    // SW x2,-4(x1)
    instr_i = 32'hFE20_AE23;
    cyc();
    chk("sw_imm", imm_o, 32'hFFFF_FFFC);
    chk("sw_rd", {27'b0, rd_addr_o}, 32'd0);
    chk("sw_rs2", {27'b0, rs2_addr_o}, 32'd2);
    chk("sw_we", {31'b0, rd_we_o}, 32'd0);
    chk("sw_f3", {29'b0, funct3_o}, 32'd0);

    // BEQ x1,x2,-8
    instr_i = 32'hFE20_8CE3;
    cyc();
    chk("beq_imm", imm_o, 32'hFFFF_FFF8);
    chk("beq_f7", {25'b0, funct7_o}, 32'h20);
    chk("beq_useimm", {31'b0, use_imm_o}, 32'd0);
    chk("beq_we", {31'b0, rd_we_o}, 32'd0);

    // LUI x5,0xABCDE
    instr_i = 32'hABCD_E2B7;
    cyc();
    chk("lui_imm", imm_o, 32'hABCD_E000);
    chk("lui_rs1", {27'b0, rs1_addr_o}, 32'd0);
    chk("lui_we", {31'b0, rd_we_o}, 32'd1);

    // JAL x1,+8
    instr_i = 32'h0080_00EF;
    cyc();
    chk("jal_imm", imm_o, 32'd8);
    chk("jal_rd", {27'b0, rd_addr_o}, 32'd1);

    // SRAI x1,x2,3
    instr_i = 32'h4031_5093;
    cyc();
    chk("srai_f3", {29'b0, funct3_o}, 32'd5);
    chk("srai_f7", {25'b0, funct7_o}, 32'h20);
    chk("srai_ill", {31'b0, illegal_o}, 32'd0);

    // Illegal encodings still flow through
    instr_i = 32'h0000_0000;
    cyc();
    chk("ill0_valid", {31'b0, dec_valid_o}, 32'd1);
    chk("ill0_ill", {31'b0, illegal_o}, 32'd1);
    chk("ill0_we", {31'b0, rd_we_o}, 32'd0);
    instr_i = 32'h0000_007F;
    cyc();
    chk("ill7f_ill", {31'b0, illegal_o}, 32'd1);
    chk("ill7f_we", {31'b0, rd_we_o}, 32'd0);
    instr_i = 32'h4000_10B3;
    cyc();
    chk("illsub_ill", {31'b0, illegal_o}, 32'd1);
    chk("illsub_we", {31'b0, rd_we_o}, 32'd0);
    chk("illsub_rd", {27'b0, rd_addr_o}, 32'd1);
    instr_i = 32'h0000_0013;
    cyc();
    chk("nop_ill", {31'b0, illegal_o}, 32'd0);
    chk("nop_we", {31'b0, rd_we_o}, 32'd0);
    instr_valid_i = 1'b0;
    cyc();
    chk("drain_valid", {31'b0, dec_valid_o}, 32'd0);

    // Backpressure: two accepted, third held by fetch
    dec_ready_i = 1'b0; instr_valid_i = 1'b1; instr_i = ADDI1;
    cyc();
    chk("bp1_valid", {31'b0, dec_valid_o}, 32'd1);
    chk("bp1_imm", imm_o, 32'd1);
    chk("bp1_ready", {31'b0, instr_ready_o}, 32'd1);
    instr_i = ADDI2;
    cyc();
    chk("bp2_ready", {31'b0, instr_ready_o}, 32'd0);
    chk("bp2_imm", imm_o, 32'd1);
    instr_i = ADDI3;
    cyc();
    chk("bp3_ready", {31'b0, instr_ready_o}, 32'd0);
    chk("bp3_imm", imm_o, 32'd1);
    dec_ready_i = 1'b1;
    cyc();
    chk("bp4_imm", imm_o, 32'd2);
    chk("bp4_valid", {31'b0, dec_valid_o}, 32'd1);
    chk("bp4_ready", {31'b0, instr_ready_o}, 32'd1);
    cyc();
    chk("bp5_imm", imm_o, 32'd3);
    chk("bp5_rd", {27'b0, rd_addr_o}, 32'd3);
    instr_valid_i = 1'b0;
    cyc();
    chk("bp6_valid", {31'b0, dec_valid_o}, 32'd0);

    // Flush in HOLD2 with an instruction on offer
    dec_ready_i = 1'b0; instr_valid_i = 1'b1; instr_i = ADDI1;
    cyc();
    instr_i = ADDI2;
    cyc();
    chk("fl_pre_ready", {31'b0, instr_ready_o}, 32'd0);
    flush_i = 1'b1; instr_i = ADDI3;
    cyc();
    chk("fl_valid", {31'b0, dec_valid_o}, 32'd0);
    chk("fl_ready", {31'b0, instr_ready_o}, 32'd1);
    flush_i = 1'b0; instr_valid_i = 1'b0; dec_ready_i = 1'b1;
    cyc();
    chk("fl_post_valid", {31'b0, dec_valid_o}, 32'd0);
    cyc();
    chk("fl_post2_valid", {31'b0, dec_valid_o}, 32'd0);

    // Asynchronous reset in HOLD2
    dec_ready_i = 1'b0; instr_valid_i = 1'b1; instr_i = ADDI1;
    cyc();
    instr_i = ADDI2;
    cyc();
    instr_valid_i = 1'b0;
    chk("ar_pre_valid", {31'b0, dec_valid_o}, 32'd1);
    chk("ar_pre_ready", {31'b0, instr_ready_o}, 32'd0);
    #2 rst_i = 1'b1;
    #1;
    chk("ar_valid", {31'b0, dec_valid_o}, 32'd0);
    chk("ar_ready", {31'b0, instr_ready_o}, 32'd1);
    chk("ar_imm", imm_o, 32'd0);
    #1 rst_i = 1'b0;
    cyc();
    chk("ar_post_valid", {31'b0, dec_valid_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
